// File: rtl/led_sequencer.sv
// Table-driven LED sequencer: plays up to eight {pattern, duration} steps on a
// 1 ms tick derived from sys_clk, optionally looping; the table is writable only while idle.
module led_sequencer #(
  parameter int         TICK_DIV = 27_000,
  parameter logic [5:0] IDLE_PAT = 6'b111111
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_addr,
  input  logic [5:0]  wr_pattern,
  input  logic [11:0] wr_dur_ms,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [2:0]  last_step,
  output logic [5:0]  onboard_led,
  output logic        busy,
  output logic [2:0]  step_idx,
  output logic        done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  last_q, last_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0] ms_q, ms_d;
  logic [5:0]  led_q, led_d;
  logic        done_q, done_d;

  logic [5:0]  pat_mem [8];
  logic [11:0] dur_mem [8];

  logic        wr_fire;
  logic [11:0] cur_dur;
  logic [11:0] cur_last_ms;
  logic        step_end;

  // Handshake: a table write commits on any rising edge where wr_valid && wr_ready;
  // wr_ready depends on state alone, so it never combinationally follows wr_valid.
  assign wr_fire = wr_valid && wr_ready;

  // A zero duration plays as 1 ms, so the last ms index is 0 for both 0 and 1.
  assign cur_dur     = dur_mem[step_q];
  assign cur_last_ms = (cur_dur == 12'd0) ? 12'd0 : cur_dur - 12'd1;
  assign step_end    = (presc_q == PRESC_MAX) && (ms_q == cur_last_ms);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        pat_mem[i] <= IDLE_PAT;
        dur_mem[i] <= 12'd0;
      end
    end else if (wr_fire) begin
      pat_mem[wr_addr] <= wr_pattern;
      dur_mem[wr_addr] <= wr_dur_ms;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      last_q  <= 3'd0;
      presc_q <= '0;
      ms_q    <= 12'd0;
      led_q   <= IDLE_PAT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      last_q  <= last_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    presc_d = presc_q;
    ms_d    = ms_q;
    led_d   = led_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop && !wr_fire) begin
          state_d = S_RUN;
          step_d  = 3'd0;
          last_d  = last_step;
          presc_d = '0;
          ms_d    = 12'd0;
          led_d   = pat_mem[0];
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          step_d  = 3'd0;
          presc_d = '0;
          ms_d    = 12'd0;
          led_d   = IDLE_PAT;
        end else if (step_end) begin
          presc_d = '0;
          ms_d    = 12'd0;
          if (step_q != last_q) begin
            step_d = step_q + 3'd1;
            led_d  = pat_mem[step_q + 3'd1];
          end else if (loop_en) begin
            step_d = 3'd0;
            led_d  = pat_mem[0];
          end else begin
            state_d = S_IDLE;
            step_d  = 3'd0;
            led_d   = IDLE_PAT;
            done_d  = 1'b1;
          end
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          ms_d    = ms_q + 12'd1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ready    = (state_q == S_IDLE);
    busy        = (state_q == S_RUN);
    onboard_led = led_q;
    step_idx    = step_q;
    done        = done_q;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer at TICK_DIV=4: directed vector table, async-reset sequence,
// then random traffic against a cycle-countdown reference model.
module tb_led_sequencer;

  localparam int         TD = 4;
  localparam logic [5:0] IP = 6'b111111;
  localparam logic [5:0] PA = 6'b101001;
  localparam logic [5:0] PB = 6'b010110;
  localparam logic [5:0] PC = 6'b110011;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [5:0]  wr_pattern;
  logic [11:0] wr_dur_ms;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [2:0]  last_step;
  logic [5:0]  onboard_led;
  logic        busy;
  logic [2:0]  step_idx;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  led_sequencer #(.TICK_DIV(TD), .IDLE_PAT(IP)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_pattern(wr_pattern), .wr_dur_ms(wr_dur_ms),
    .start(start), .stop(stop), .loop_en(loop_en), .last_step(last_step),
    .onboard_led(onboard_led), .busy(busy), .step_idx(step_idx), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: remaining-cycle countdown per step.
  logic [5:0]  m_pat [8];
  logic [11:0] m_dur [8];
  logic        m_run;
  logic [2:0]  m_step;
  logic [2:0]  m_last;
  int          m_left;
  logic [5:0]  m_led;
  logic        m_done;

  function automatic int step_len(input logic [11:0] d);
    return ((d == 12'd0) ? 1 : int'(d)) * TD;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_pat[i] = IP;
      m_dur[i] = 12'd0;
    end
    m_run = 0; m_step = 0; m_last = 0; m_left = 0; m_led = IP; m_done = 0;
  endtask

  task automatic model_enter(input logic [2:0] s);
    m_step = s;
    m_led  = m_pat[s];
    m_left = step_len(m_dur[s]);
  endtask

  task automatic model_edge();
    m_done = 0;
    if (!m_run) begin
      if (wr_valid) begin
        m_pat[wr_addr] = wr_pattern;
        m_dur[wr_addr] = wr_dur_ms;
      end else if (start && !stop) begin
        m_run  = 1;
        m_last = last_step;
        model_enter(3'd0);
      end
    end else if (stop) begin
      m_run = 0; m_step = 0; m_led = IP;
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_step != m_last) model_enter(m_step + 3'd1);
        else if (loop_en) model_enter(3'd0);
        else begin
          m_run = 0; m_step = 0; m_led = IP; m_done = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [5:0] e_led, input logic e_busy,
                          input logic [2:0] e_step, input logic e_done, input logic e_rdy);
    chk({tag, ".led"},   32'(onboard_led), 32'(e_led));
    chk({tag, ".busy"},  32'(busy),        32'(e_busy));
    chk({tag, ".step"},  32'(step_idx),    32'(e_step));
    chk({tag, ".done"},  32'(done),        32'(e_done));
    chk({tag, ".ready"}, 32'(wr_ready),    32'(e_rdy));
  endtask

  // One clock: advance the model on the inputs presented, then sample #1 after the edge.
  task automatic cyc();
    model_edge();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_in(input logic wv, input logic [2:0] wa, input logic [5:0] wp,
                        input logic [11:0] wd, input logic st, input logic sp,
                        input logic le, input logic [2:0] ls);
    wr_valid = wv; wr_addr = wa; wr_pattern = wp; wr_dur_ms = wd;
    start = st; stop = sp; loop_en = le; last_step = ls;
  endtask

  typedef struct {
    logic        wv;
    logic [2:0]  wa;
    logic [5:0]  wp;
    logic [11:0] wd;
    logic        st, sp, le;
    logic [2:0]  ls;
    int          n;
    logic [5:0]  e_led;
    logic        e_busy;
    logic [2:0]  e_step;
    logic        e_done;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wv, input logic [2:0] wa, input logic [5:0] wp,
                              input logic [11:0] wd, input logic st, input logic sp,
                              input logic le, input logic [2:0] ls, input int n,
                              input logic [5:0] e_led, input logic e_busy,
                              input logic [2:0] e_step, input logic e_done, input logic e_rdy);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wp = wp; v.wd = wd; v.st = st; v.sp = sp; v.le = le; v.ls = ls;
    v.n = n; v.e_led = e_led; v.e_busy = e_busy; v.e_step = e_step; v.e_done = e_done;
    v.e_rdy = e_rdy;
    return v;
  endfunction

  initial begin
    // Each record: inputs held for n cycles; expected outputs after every one of those edges.
    vecs.push_back(mk(1, 0, PA, 2, 0, 0, 0, 0, 1, IP, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, PB, 1, 0, 0, 0, 0, 1, IP, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, PA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, PA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, PB, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, IP, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, IP, 0, 0, 0, 1));
    // looping: 8/4/8/4, no done, then stop coinciding with a step end
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 1, PA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 7, PA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 4, PB, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 8, PA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 4, PB, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, IP, 0, 0, 0, 1));
    // stop three cycles into step 0
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, PA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, PA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, IP, 0, 0, 0, 1));
    // write attempts during RUN must be refused
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, PA, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 5, 0, 0, 0, 1, 7, PA, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 5, 0, 0, 0, 1, 4, PB, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, IP, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, PA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, PA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, IP, 0, 0, 1, 1));
    // write with start in IDLE: write wins, stays IDLE; then dur=0 plays as 4 cycles
    vecs.push_back(mk(1, 0, PC, 0, 1, 0, 0, 0, 1, IP, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, IP, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, PC, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, PC, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, IP, 0, 0, 1, 1));
    // last_step changed during RUN is ignored; start+stop in IDLE stays IDLE
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, PC, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, PC, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 4, PB, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, IP, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 2, IP, 0, 0, 0, 1));

    // clock/reset
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    chk_outs("reset", IP, 0, 0, 0, 1);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].wv, vecs[i].wa, vecs[i].wp, vecs[i].wd,
             vecs[i].st, vecs[i].sp, vecs[i].le, vecs[i].ls);
      for (int k = 0; k < vecs[i].n; k++) begin
        cyc();
        chk_outs($sformatf("v%0d.c%0d", i, k), vecs[i].e_led, vecs[i].e_busy,
                 vecs[i].e_step, vecs[i].e_done, vecs[i].e_rdy);
      end
    end

    // Async reset mid-step: entry 0 = PC/dur0, entry 1 = PB/dur1, running with last_step=1.
    set_in(0, 0, 0, 0, 1, 0, 0, 1);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (5) cyc();
    chk_outs("rst.pre", PB, 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("rst.async", IP, 0, 0, 0, 1);
    model_reset();
    @(posedge sys_clk);
    #1;
    chk_outs("rst.hold", IP, 0, 0, 0, 1);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk_outs($sformatf("rst.after%0d", k), IP, 0, 0, 0, 1);
    end
    // Cleared table: pattern IDLE_PAT, dur 0 -> 4-cycle step, then done.
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk_outs("clr.c0", IP, 1, 0, 0, 0);
    repeat (3) cyc();
    chk_outs("clr.c3", IP, 1, 0, 0, 0);
    cyc();
    chk_outs("clr.done", IP, 0, 0, 1, 1);

    // Random traffic against the reference model.
    for (int k = 0; k < 4000; k++) begin
      set_in($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
             12'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
             $urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)));
      cyc();
      chk_outs($sformatf("rnd%0d", k), m_led, m_run, m_step, m_done, !m_run);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 27_000, meaning sys_clk cycles per 1 ms tick.
REQ-002 SHALL have parameter IDLE_PAT, default 6'b111111, meaning the LED value driven when not running (all LEDs off, active-low board).
REQ-003 SHALL have port sys_clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  table write request.
REQ-006 SHALL have port wr_ready  output  1  table write accepted when high with wr_valid.
REQ-007 SHALL have port wr_addr  input  3  table entry index 0..7.
REQ-008 SHALL have port wr_pattern  input  6  LED pattern for the entry.
REQ-009 SHALL have port wr_dur_ms  input  12  step duration in ms.
REQ-010 SHALL have port start  input  1  begin sequence (level sampled each cycle).
REQ-011 SHALL have port stop  input  1  abort sequence.
REQ-012 SHALL have port loop_en  input  1  1 = repeat from step 0 after last step.
REQ-013 SHALL have port last_step  input  3  index of final step, sampled at start.
REQ-014 SHALL have port onboard_led  output  6  registered LED drive.
REQ-015 SHALL have port busy  output  1  high while in RUN.
REQ-016 SHALL have port step_idx  output  3  current step index.
REQ-017 SHALL have port done  output  1  one-cycle pulse at normal sequence completion.

Function
REQ-018 SHALL implement an 8-entry table of {pattern[5:0], dur[11:0]} and states IDLE and RUN.
REQ-019 SHALL drive wr_ready = (state==IDLE), combinationally from state only; a write commits on the edge where wr_valid&&wr_ready.
REQ-020 SHALL ignore start in any IDLE cycle where a write commits (wr_valid&&wr_ready).
REQ-021 SHALL, on start=1 in IDLE (no write, stop=0), enter RUN next edge with step_idx=0, onboard_led=table[0].pattern, busy=1, and last_step latched.
REQ-022 SHALL treat dur=0 as 1 ms; each step SHALL last exactly max(dur,1)*TICK_DIV cycles, counted by a cycle prescaler (0..TICK_DIV-1) and a 12-bit ms counter, both cleared at step entry.
REQ-023 SHALL, at the end of a step with step_idx<latched last_step, advance step_idx by 1 and load that entry's pattern on the same edge.
REQ-024 SHALL, at the end of step latched last_step, wrap to step 0 with loop_en=1 (no done pulse), else go IDLE, drive onboard_led=IDLE_PAT, busy=0, step_idx=0 and pulse done for exactly one cycle.
REQ-025 SHALL, on stop=1 in RUN, go IDLE next edge with onboard_led=IDLE_PAT, busy=0, step_idx=0, no done pulse; stop SHALL win over a simultaneous step end.
REQ-026 SHALL ignore start while in RUN and ignore stop while in IDLE; start and stop together in IDLE SHALL leave the block in IDLE.
REQ-027 SHALL sample loop_en at each wrap decision; changes to last_step during RUN SHALL have no effect.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force state=IDLE, onboard_led=IDLE_PAT, busy=0, step_idx=0, done=0, counters=0, all table entries pattern=IDLE_PAT dur=0.
REQ-029 SHALL apply reset mid-RUN immediately, with no done pulse, and the sequence SHALL not resume after release.

Verification (TICK_DIV=4)
REQ-030 SHALL cover: write entries 0:{6'b101001,2} 1:{6'b010110,1}, last_step=1, loop_en=0, start -> led 101001 for 8 cycles, 010110 for 4 cycles, then IDLE_PAT with done high 1 cycle.
REQ-031 SHALL cover: same table, loop_en=1 -> pattern sequence 8/4/8/4 cycles repeats, done never asserted, busy stays 1.
REQ-032 SHALL cover: stop asserted 3 cycles into step 0 -> led=IDLE_PAT, busy=0 next edge, no done; wr_ready returns to 1.
REQ-033 SHALL cover: entry 0 dur=0 -> step 0 lasts exactly 4 cycles.
REQ-034 SHALL cover: wr_valid held during RUN -> wr_ready=0, table unchanged; wr_valid and start together in IDLE -> write commits, state stays IDLE.
REQ-035 SHALL cover: rst_n low mid-step -> outputs at reset values within the same cycle, table cleared, done never pulses.
